// File: rtl/sensor_conditioner.sv
// Synchronizes and debounces the outer/inner photo-sensor levels; clean level changes STABLE_CYCLES+2 edges
// after raw first sampled. Edge pulses and a saturating glitch count are registered; no backpressure.
module sensor_conditioner #(
  parameter int STABLE_CYCLES = 500000,
  localparam int CNT_W = $clog2(STABLE_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       outer_raw,
  input  logic       inner_raw,
  output logic       outer,
  output logic       inner,
  output logic       outer_rise,
  output logic       outer_fall,
  output logic       inner_rise,
  output logic       inner_fall,
  output logic [7:0] glitch_cnt
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [1:0] raw_vec;
  logic [1:0] clean_vec;
  logic [1:0] rise_vec;
  logic [1:0] fall_vec;
  logic [1:0] glitch_evt;

  assign raw_vec = {inner_raw, outer_raw};

  for (genvar g = 0; g < 2; g++) begin : ch_g
    logic             ff1_q;
    logic             sync_q;
    logic             clean_q;
    logic             rise_q;
    logic             fall_q;
    logic [CNT_W-1:0] cnt_q;

    // A return to the clean level with a run in progress is a rejected excursion.
    assign glitch_evt[g] = (sync_q == clean_q) && (cnt_q != '0);

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        ff1_q   <= 1'b0;
        sync_q  <= 1'b0;
        clean_q <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
        cnt_q   <= '0;
      end else begin
        ff1_q  <= raw_vec[g];
        sync_q <= ff1_q;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        if (sync_q == clean_q) begin
          cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
          clean_q <= sync_q;
          cnt_q   <= '0;
          rise_q  <= sync_q;
          fall_q  <= ~sync_q;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end

    assign clean_vec[g] = clean_q;
    assign rise_vec[g]  = rise_q;
    assign fall_vec[g]  = fall_q;
  end

  logic [8:0] glitch_sum;

  assign glitch_sum = {1'b0, glitch_cnt} + {8'd0, glitch_evt[0]} + {8'd0, glitch_evt[1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      glitch_cnt <= 8'd0;
    end else if (glitch_sum[8]) begin
      glitch_cnt <= 8'hFF;
    end else begin
      glitch_cnt <= glitch_sum[7:0];
    end
  end

  assign outer      = clean_vec[0];
  assign inner      = clean_vec[1];
  assign outer_rise = rise_vec[0];
  assign outer_fall = fall_vec[0];
  assign inner_rise = rise_vec[1];
  assign inner_fall = fall_vec[1];

endmodule

// File: tb/tb_sensor_conditioner.sv
// Randomized and directed bench for sensor_conditioner with a run-length reference model.
module tb_sensor_conditioner;

  localparam int STABLE = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       outer_raw = 1'b0;
  logic       inner_raw = 1'b0;
  logic       outer, inner;
  logic       outer_rise, outer_fall, inner_rise, inner_fall;
  logic [7:0] glitch_cnt;

  int checks = 0;
  int errors = 0;

  sensor_conditioner #(.STABLE_CYCLES(STABLE)) dut (
    .clk        (clk),
    .reset      (reset),
    .outer_raw  (outer_raw),
    .inner_raw  (inner_raw),
    .outer      (outer),
    .inner      (inner),
    .outer_rise (outer_rise),
    .outer_fall (outer_fall),
    .inner_rise (inner_rise),
    .inner_fall (inner_fall),
    .glitch_cnt (glitch_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: raw samples reach the debouncer two edges late; a level is
  // accepted once it has been seen STABLE edges in a row differing from clean.
  logic [1:0] h1, h2, m_clean, m_rise, m_fall;
  int         run [2];
  int         m_glitch;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      h1 = '0; h2 = '0; m_clean = '0; m_rise = '0; m_fall = '0;
      run[0] = 0; run[1] = 0;
      m_glitch = 0;
    end else begin
      int n;
      logic [1:0] raw_now;
      n = 0;
      raw_now = {inner_raw, outer_raw};
      for (int c = 0; c < 2; c++) begin
        m_rise[c] = 1'b0;
        m_fall[c] = 1'b0;
        if (h2[c] == m_clean[c]) begin
          if (run[c] > 0) n++;
          run[c] = 0;
        end else begin
          run[c]++;
          if (run[c] == STABLE) begin
            m_clean[c] = h2[c];
            run[c] = 0;
            m_rise[c] = h2[c];
            m_fall[c] = ~h2[c];
          end
        end
        h2[c] = h1[c];
        h1[c] = raw_now[c];
      end
      m_glitch = (m_glitch + n > 255) ? 255 : m_glitch + n;
    end
  end

  always @(negedge clk) begin
    check("outer", outer, m_clean[0]);
    check("inner", inner, m_clean[1]);
    check("outer_rise", outer_rise, m_rise[0]);
    check("outer_fall", outer_fall, m_fall[0]);
    check("inner_rise", inner_rise, m_rise[1]);
    check("inner_fall", inner_fall, m_fall[1]);
    check("glitch_cnt", glitch_cnt, m_glitch);
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Outer raw was just set to 1 at a negedge with outer clean at 0.
  task automatic pin_outer_latency(input string tag);
    for (int e = 1; e <= 7; e++) begin
      @(posedge clk);
      #1;
      if (e == 5) check({tag, "_pre_outer"}, outer, 0);
      if (e == 6) begin
        check({tag, "_outer"}, outer, 1);
        check({tag, "_rise"}, outer_rise, 1);
        check({tag, "_fall"}, outer_fall, 0);
      end
      if (e == 7) check({tag, "_rise_gone"}, outer_rise, 0);
    end
    check({tag, "_inner"}, inner, 0);
  endtask

  task automatic glitch_once(input bit both);
    @(negedge clk);
    outer_raw = ~m_clean[0];
    if (both) inner_raw = ~m_clean[1];
    wait_neg(2);
    outer_raw = m_clean[0];
    inner_raw = m_clean[1];
    wait_neg(4);
  endtask

  initial begin
    int guard;
    int hold_o, hold_i;

    wait_neg(3);
    check("rst_outer", outer, 0);
    check("rst_glitch", glitch_cnt, 0);

    // Power-up with raw already high: normal rise after full latency.
    reset = 1'b0;
    outer_raw = 1'b1;
    pin_outer_latency("powerup");
    wait_neg(3);

    // Short low excursion on a stable high level.
    outer_raw = 1'b0;
    wait_neg(3);
    outer_raw = 1'b1;
    wait_neg(6);
    check("glitch3_cnt", glitch_cnt, 1);
    check("glitch3_outer", outer, 1);

    // Simultaneous rise on both channels, then a dual glitch.
    outer_raw = 1'b0;
    wait_neg(10);
    outer_raw = 1'b1;
    inner_raw = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("dual_outer_rise", outer_rise, 1);
    check("dual_inner_rise", inner_rise, 1);
    wait_neg(4);
    outer_raw = 1'b0;
    inner_raw = 1'b0;
    wait_neg(2);
    outer_raw = 1'b1;
    inner_raw = 1'b1;
    wait_neg(6);
    check("dual_glitch_cnt", glitch_cnt, 3);

    // Pulses at and just above the acceptance boundary.
    outer_raw = 1'b0;
    wait_neg(10);
    for (int w = 3; w <= 5; w++) begin
      outer_raw = 1'b1;
      wait_neg(w);
      outer_raw = 1'b0;
      wait_neg(12);
    end

    // Drive the counter to 254, then saturate with dual glitches.
    guard = 0;
    while (m_glitch < 254 && guard < 300) begin
      glitch_once(m_glitch <= 252);
      guard++;
    end
    check("sat_reach_254", m_glitch, 254);
    glitch_once(1'b1);
    check("sat_255", glitch_cnt, 255);
    glitch_once(1'b1);
    check("sat_hold", glitch_cnt, 255);
    glitch_once(1'b0);
    check("sat_hold_single", glitch_cnt, 255);

    // Random independent toggling of both channels.
    hold_o = 1;
    hold_i = 1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (--hold_o == 0) begin
        outer_raw = ~outer_raw;
        hold_o = $urandom_range(1, 8);
      end
      if (--hold_i == 0) begin
        inner_raw = ~inner_raw;
        hold_i = $urandom_range(1, 8);
      end
    end

    // Async reset between edges with a pending fall (count at 3).
    outer_raw = 1'b1;
    inner_raw = 1'b0;
    wait_neg(12);
    check("pre_abort_outer", outer, 1);
    outer_raw = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("abort_outer", outer, 0);
    check("abort_inner", inner, 0);
    check("abort_outer_fall", outer_fall, 0);
    check("abort_glitch", glitch_cnt, 0);
    outer_raw = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    pin_outer_latency("rerelease");
    wait_neg(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
